// File: rtl/ff_bank_arbiter.sv
// ff_bank_arbiter: one WIDTH-bit flip-flop bank shared by NREQ requesters via round-robin.
// The winner's word is loaded (D) or XORed (T) into q under a 4-phase req/gnt handshake.
module ff_bank_arbiter #(
    parameter int  NREQ    = 4,
    parameter int  WIDTH   = 8,
    parameter int  FF_TYPE = 0,
    parameter int  CW      = 8,
    localparam int OW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [OW-1:0]         owner,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      q,
    output logic [CW-1:0]         count
);

    typedef enum logic [1:0] {StIdle, StGrant, StApply, StWaitRel} state_e;

    localparam logic [NREQ-1:0] GntOne = NREQ'(1);

    state_e           state;
    logic [OW-1:0]    last;
    logic [OW-1:0]    win;
    logic [OW-1:0]    idx;
    logic [WIDTH-1:0] hold;

    // Scan from lowest to highest priority so the last hit is the round-robin winner.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = OW'((int'(last) + k) % NREQ);
            if (req[idx]) begin
                win = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            gnt   <= '0;
            owner <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            q     <= '0;
            count <= '0;
            last  <= OW'(NREQ - 1);
            hold  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (|req) begin
                        gnt   <= GntOne << win;
                        owner <= win;
                        busy  <= 1'b1;
                        state <= StGrant;
                    end
                end
                StGrant: begin
                    if (req[owner]) begin
                        hold  <= wdata[int'(owner)*WIDTH +: WIDTH];
                        state <= StApply;
                    end else begin
                        // Requester withdrew before its word was taken: no update.
                        gnt   <= '0;
                        last  <= owner;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                StApply: begin
                    q     <= (FF_TYPE == 1) ? (q ^ hold) : hold;
                    done  <= 1'b1;
                    count <= count + CW'(1);
                    state <= StWaitRel;
                end
                StWaitRel: begin
                    if (!req[owner]) begin
                        gnt   <= '0;
                        last  <= owner;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Bench for ff_bank_arbiter: D- and T-mode instances share stimulus; a scoreboard queue
// of expected results from a round-robin reference model is drained on every done pulse.
`timescale 1ns/1ps
module tb_ff_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int CW    = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt_d, gnt_t;
    logic [1:0]            owner_d, owner_t;
    logic                  busy_d, busy_t, done_d, done_t;
    logic [WIDTH-1:0]      q_d, q_t;
    logic [CW-1:0]         count_d, count_t;

    always #5 clk = ~clk;

    ff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .FF_TYPE(0), .CW(CW)) dut_d (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt_d), .owner(owner_d),
        .busy(busy_d), .done(done_d), .q(q_d), .count(count_d)
    );

    ff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .FF_TYPE(1), .CW(CW)) dut_t (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt_t), .owner(owner_t),
        .busy(busy_t), .done(done_t), .q(q_t), .count(count_t)
    );

    typedef struct {
        int         w;
        logic [7:0] qd;
        logic [7:0] qt;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state
    int              m_last;
    logic [7:0]      m_qd, m_qt, m_cnt;
    logic [NREQ-1:0] pending;
    logic [7:0]      word[NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = word[i];
        req = pending;
    endtask

    task automatic model_reset();
        m_last  = NREQ - 1;
        m_qd    = '0;
        m_qt    = '0;
        m_cnt   = '0;
        pending = '0;
        sb.delete();
        drive();
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= NREQ; k++) begin
            if (pending[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic raise(input int i, input logic [7:0] data);
        pending[i] = 1'b1;
        word[i]    = data;
        drive();
    endtask

    // Called with the DUT idle; the next rising edge arbitrates over the pending set.
    task automatic step(input bit abort, input int holdk);
        int   w;
        logic got;
        w = rr_pick();
        if (w >= 0) begin
            if (abort) begin
                @(posedge clk); #1;
                chk("abort_grant", gnt_d, 32'(1) << w);
                pending[w] = 1'b0;
                drive();
                m_last = w;
                @(posedge clk); #1;
                chk("abort_gnt_low", gnt_d, 0);
                chk("abort_q_unchanged", q_d, m_qd);
            end else begin
                m_cnt = m_cnt + 8'd1;
                m_qd  = word[w];
                m_qt  = m_qt ^ word[w];
                sb.push_back('{w: w, qd: m_qd, qt: m_qt, cnt: m_cnt});
                @(posedge clk); #1;
                chk("grant", gnt_d, 32'(1) << w);
                chk("busy_grant", busy_d, 1);
                @(posedge clk); #1;
                // Word already captured; later changes must not reach q.
                word[w] = ~word[w];
                drive();
                got = 1'b0;
                for (int c = 0; c < 8 && !got; c++) begin
                    @(negedge clk);
                    got = done_d;
                end
                chk("done_seen", got, 1);
                for (int c = 0; c < holdk; c++) begin
                    @(negedge clk);
                    chk("hold_gnt", gnt_d, 32'(1) << w);
                end
                pending[w] = 1'b0;
                drive();
                m_last = w;
                @(posedge clk); #1;
                chk("release_gnt", gnt_d, 0);
                chk("release_busy", busy_d, 0);
            end
        end
    endtask

    // Monitor: every done pulse must match the oldest expected update.
    initial begin
        forever begin
            @(negedge clk);
            if (done_d || done_t) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(done_d | done_t), 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_d", done_d, 1);
                    chk("done_t", done_t, 1);
                    chk("owner", owner_d, e.w);
                    chk("gnt_at_done", gnt_d, 32'(1) << e.w);
                    chk("q_dmode", q_d, e.qd);
                    chk("q_tmode", q_t, e.qt);
                    chk("count", count_d, e.cnt);
                    chk("busy_at_done", busy_d, 1);
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        req     = '0;
        wdata   = '0;
        pending = '0;
        for (int i = 0; i < NREQ; i++) word[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", gnt_d, 0);
        chk("rst_busy", busy_d, 0);
        chk("rst_done", done_d, 0);
        chk("rst_q", q_d, 0);
        chk("rst_count", count_d, 0);
        chk("rst_owner", owner_d, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Single D-mode load, then T-mode toggling by requester 2
        raise(0, 8'hA5);
        step(1'b0, 0);
        chk("count_first", count_d, 1);
        chk("q_first", q_d, 8'hA5);
        raise(2, 8'h0F);
        step(1'b0, 1);
        chk("t_first", q_t, 8'hAA);
        raise(2, 8'h0F);
        step(1'b0, 0);
        chk("t_second", q_t, 8'hA5);

        // Requester 0 withdraws during GRANT; requester 1 must be served next
        raise(0, 8'h11);
        raise(1, 8'h22);
        step(1'b1, 0);
        step(1'b0, 0);
        chk("after_abort_owner", owner_d, 1);

        // Reset in the middle of APPLY with q = 3C
        raise(0, 8'h3C);
        step(1'b0, 0);
        raise(1, 8'h77);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_q", q_d, 0);
        chk("midrst_gnt", gnt_d, 0);
        chk("midrst_busy", busy_d, 0);
        chk("midrst_done", done_d, 0);
        chk("midrst_count", count_d, 0);
        pending = '0;
        drive();
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // All four requesting: order 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) raise(i, 8'($urandom));
        for (int n = 0; n < 5; n++) begin
            step(1'b0, 0);
            for (int i = 0; i < NREQ; i++) if (!pending[i]) raise(i, 8'($urandom));
        end

        // Random traffic, enough completions to wrap the counter
        for (int it = 0; it < 300; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) raise(i, 8'($urandom));
            end
            if (pending == '0) raise(int'($urandom_range(0, NREQ - 1)), 8'($urandom));
            step($urandom_range(0, 9) == 0, int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
